// File: rtl/dport_linefetch_if.sv
// Memory read port of the display line fetcher: a single-outstanding
// request/acknowledge bus carrying 32-bit words (two 16-bit pixels).
interface dport_linefetch_if #(
    parameter int AW = 32
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    // The fetcher drives the request side.
    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    // The memory answers with ack and same-cycle read data.
    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/dport_linefetch.sv
// Display-port line fetcher: on each horizontal DMA start it reads one
// framebuffer line word by word and streams the 16-bit pixels, low half
// first, into the display FIFO. Line addresses come from an accumulator
// that advances by the stride at every line start and is reloaded on vblank.
module dport_linefetch #(
    parameter int AW = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [AW-1:0]          fbbase,
    input  logic [15:0]            stride,
    input  logic [11:0]            hpixels,
    input  logic [11:0]            vlines,
    input  logic                   dmahstart,
    input  logic                   vblank,
    dport_linefetch_if.master      mem,
    output logic                   pixel_valid,
    output logic [15:0]            pixel_data,
    output logic                   overrun
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        EMIT0,
        EMIT1
    } state_t;

    state_t        state, state_d;
    logic          line_start;
    logic          line_done;
    logic          mem_req_c;
    logic [AW-1:0] acc;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] base_now;
    logic [11:0]   linectr;
    logic [11:0]   pix_left;
    logic [31:0]   rdata_q;

    // A vblank in the same cycle as a line start makes that line line 0.
    assign base_now     = vblank ? fbbase : acc;
    assign mem.mem_req  = mem_req_c;
    assign mem.mem_addr = addr_q;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state and output decode.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d     = state;
        line_start  = 1'b0;
        line_done   = 1'b0;
        mem_req_c   = 1'b0;
        pixel_valid = 1'b0;
        pixel_data  = 16'h0000;
        case (state)
            IDLE: begin
                if (dmahstart && enable && (vblank || (linectr < vlines))) begin
                    line_start = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                mem_req_c = 1'b1;
                if (mem.mem_ack) state_d = EMIT0;
            end
            EMIT0: begin
                pixel_valid = 1'b1;
                pixel_data  = rdata_q[15:0];
                if (pix_left <= 12'd1) begin
                    line_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = EMIT1;
                end
            end
            EMIT1: begin
                pixel_valid = 1'b1;
                pixel_data  = rdata_q[31:16];
                if (pix_left <= 12'd1) begin
                    line_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address accumulator, word address, pixel and line counters, overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= fbbase;
            addr_q   <= '0;
            linectr  <= 12'd0;
            pix_left <= 12'd0;
            overrun  <= 1'b0;
        end else begin
            if (dmahstart && (state != IDLE)) overrun <= 1'b1;

            if (line_start) begin
                addr_q   <= base_now;
                acc      <= base_now + AW'(stride);
                pix_left <= hpixels;
            end else if (vblank) begin
                acc <= fbbase;
            end

            if ((state == REQ) && mem.mem_ack) addr_q <= addr_q + AW'(4);

            if (((state == EMIT0) || (state == EMIT1)) && (pix_left != 12'd0))
                pix_left <= pix_left - 12'd1;

            if (vblank)         linectr <= 12'd0;
            else if (line_done) linectr <= linectr + 12'd1;
        end
    end

    // Read-data holding register.
    always_ff @(posedge clk) begin
        // NOTE: this data register has no reset; it is only observed in the
        // EMIT states, which are always preceded by a fresh load.
        if ((state == REQ) && mem.mem_ack) rdata_q <= mem.mem_rdata;
    end

endmodule

// File: tb/tb_dport_linefetch.sv
// Self-checking bench for dport_linefetch: a line-level model predicts the
// request addresses and pixel stream from the addressing rules; a compare
// process checks the DUT against it every cycle.
module tb_dport_linefetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] fbbase = 32'h0000_1000;
    logic [15:0] stride = 16'h0800;
    logic [11:0] hpixels = 12'd4;
    logic [11:0] vlines = 12'd100;
    logic        dmahstart = 1'b0;
    logic        vblank = 1'b0;
    logic        pixel_valid;
    logic [15:0] pixel_data;
    logic        overrun;

    dport_linefetch_if #(.AW(32)) mem_if ();

    dport_linefetch #(.AW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .fbbase      (fbbase),
        .stride      (stride),
        .hpixels     (hpixels),
        .vlines      (vlines),
        .dmahstart   (dmahstart),
        .vblank      (vblank),
        .mem         (mem_if.master),
        .pixel_valid (pixel_valid),
        .pixel_data  (pixel_data),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Memory contents: low pixel is the address, high pixel a scrambled copy.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5A5, a[15:0]};
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] exp_addr[$];
    logic [15:0] exp_pix[$];
    logic [31:0] req_log[$];
    logic [15:0] pix_log[$];
    int          m_left = 0;
    int          m_linectr = 0;
    logic [31:0] m_acc;
    logic        exp_overrun = 1'b0;
    logic        ovr_pend = 1'b0;

    task automatic model_reset();
        exp_addr.delete();
        exp_pix.delete();
        m_left      = 0;
        m_linectr   = 0;
        m_acc       = fbbase;
        exp_overrun = 1'b0;
        ovr_pend    = 1'b0;
    endtask

    task automatic model_pulse(input bit vb, input bit dh);
        logic [31:0] line_addr;
        int          words;
        if (vb) begin
            m_linectr = 0;
            m_acc     = fbbase;
        end
        if (dh) begin
            if (m_left != 0) begin
                ovr_pend = 1'b1;
            end else if (enable && (m_linectr < int'(vlines))) begin
                line_addr = m_acc;
                m_acc     = m_acc + {16'h0000, stride};
                m_left    = int'(hpixels);
                words     = (int'(hpixels) + 1) / 2;
                for (int k = 0; k < words; k++) begin
                    logic [31:0] a;
                    logic [31:0] w;
                    a = line_addr + 32'(4 * k);
                    w = mem_word(a);
                    exp_addr.push_back(a);
                    exp_pix.push_back(w[15:0]);
                    if (2 * k + 1 < int'(hpixels)) exp_pix.push_back(w[31:16]);
                end
            end
        end
    endtask

    // The overrun flag becomes visible the cycle after the offending pulse.
    initial begin
        forever begin
            @(posedge clk);
            if (ovr_pend) begin
                exp_overrun = 1'b1;
                ovr_pend    = 1'b0;
            end
        end
    end

    // ---------------- memory responder ----------------
    bit auto_ack = 1'b1;
    int ack_lat  = 2;

    initial begin
        int wcnt;
        wcnt = 0;
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!auto_ack) begin
                wcnt = 0;
            end else if (mem_if.mem_ack) begin
                mem_if.mem_ack = 1'b0;
                wcnt = 0;
            end else if (mem_if.mem_req) begin
                if (wcnt >= ack_lat) begin
                    mem_if.mem_ack   = 1'b1;
                    mem_if.mem_rdata = mem_word(mem_if.mem_addr);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset) begin
            check("overrun", {31'b0, overrun}, {31'b0, exp_overrun});
            if (mem_if.mem_req) begin
                check("req_expected", {31'b0, exp_addr.size() != 0}, 32'd1);
                if (mem_if.mem_ack && exp_addr.size() != 0) begin
                    check("req_addr", mem_if.mem_addr, exp_addr[0]);
                    req_log.push_back(mem_if.mem_addr);
                    void'(exp_addr.pop_front());
                end
            end
            if (pixel_valid) begin
                check("pix_expected", {31'b0, exp_pix.size() != 0}, 32'd1);
                if (exp_pix.size() != 0) begin
                    check("pix_data", {16'h0, pixel_data}, {16'h0, exp_pix[0]});
                    void'(exp_pix.pop_front());
                end
                pix_log.push_back(pixel_data);
                if (m_left > 0) begin
                    m_left--;
                    if (m_left == 0) m_linectr++;
                end
            end else begin
                check("pix_idle_zero", {16'h0, pixel_data}, 32'h0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse(input bit vb, input bit dh);
        @(posedge clk);
        #1;
        vblank    = vb;
        dmahstart = dh;
        model_pulse(vb, dh);
        @(posedge clk);
        #1;
        vblank    = 1'b0;
        dmahstart = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (m_left == 0) && (exp_addr.size() == 0);
        end
        check("line_done_in_time", {31'b0, done}, 32'd1);
        repeat (3) @(posedge clk);
    endtask

    task automatic clear_logs();
        req_log.delete();
        pix_log.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        check({tag, "_mem_req"}, {31'b0, mem_if.mem_req}, 32'd0);
        check({tag, "_mem_addr"}, mem_if.mem_addr, 32'd0);
        check({tag, "_pix_valid"}, {31'b0, pixel_valid}, 32'd0);
        check({tag, "_pix_data"}, {16'h0, pixel_data}, 32'd0);
        check({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("rst");

        // Basic line at 0x1000, four pixels, ack latency 2.
        clear_logs();
        pulse(1'b0, 1'b1);
        wait_done();
        check("basic_nreq", req_log.size(), 32'd2);
        check("basic_npix", pix_log.size(), 32'd4);
        if (req_log.size() == 2) begin
            check("basic_addr0", req_log[0], 32'h0000_1000);
            check("basic_addr1", req_log[1], 32'h0000_1004);
        end
        if (pix_log.size() == 4) begin
            check("basic_pix0", {16'h0, pix_log[0]}, 32'h1000);
            check("basic_pix1", {16'h0, pix_log[1]}, 32'hB5A5);
            check("basic_pix2", {16'h0, pix_log[2]}, 32'h1004);
            check("basic_pix3", {16'h0, pix_log[3]}, 32'hB5A1);
        end

        // Two more lines advance by the stride; vblank returns to fbbase.
        clear_logs();
        pulse(1'b0, 1'b1);
        wait_done();
        pulse(1'b0, 1'b1);
        wait_done();
        check("stride_nreq", req_log.size(), 32'd4);
        if (req_log.size() == 4) begin
            check("stride_line1", req_log[0], 32'h0000_1800);
            check("stride_line2", req_log[2], 32'h0000_2000);
        end
        clear_logs();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_done();
        if (req_log.size() != 0) check("vblank_restart", req_log[0], 32'h0000_1000);
        else check("vblank_restart_nreq", req_log.size(), 32'd2);

        // Odd width: three strobes from two words.
        hpixels = 12'd3;
        clear_logs();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        wait_done();
        check("odd_nreq", req_log.size(), 32'd2);
        check("odd_npix", pix_log.size(), 32'd3);
        if (pix_log.size() == 3) check("odd_last", {16'h0, pix_log[2]}, 32'h1004);

        // vblank with dmahstart in the same cycle starts line 0.
        clear_logs();
        pulse(1'b1, 1'b1);
        wait_done();
        if (req_log.size() != 0) check("vb_same_cycle", req_log[0], 32'h0000_1000);
        else check("vb_same_cycle_nreq", req_log.size(), 32'd2);

        // Line limit: third line of a two-line frame is refused.
        hpixels = 12'd4;
        vlines  = 12'd2;
        clear_logs();
        pulse(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b1);
            wait_done();
        end
        check("limit_nreq", req_log.size(), 32'd4);
        check("limit_overrun", {31'b0, overrun}, 32'd0);

        // Disabled scanout starts nothing.
        vlines = 12'd100;
        enable = 1'b0;
        clear_logs();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        repeat (10) @(posedge clk);
        check("disabled_nreq", req_log.size(), 32'd0);
        enable = 1'b1;

        // Overrun: a pulse during EMIT0 sets the sticky flag only.
        clear_logs();
        pulse(1'b0, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                @(negedge clk);
                seen = mem_if.mem_ack;
            end
            check("ovr_ack_seen", {31'b0, seen}, 32'd1);
        end
        pulse(1'b0, 1'b1);
        wait_done();
        check("ovr_flag", {31'b0, overrun}, 32'd1);
        check("ovr_nreq", req_log.size(), 32'd2);
        check("ovr_npix", pix_log.size(), 32'd4);
        repeat (5) @(posedge clk);
        check("ovr_sticky", {31'b0, overrun}, 32'd1);

        // Reset while in REQ with the ack arriving one cycle later.
        auto_ack = 1'b0;
        pulse(1'b0, 1'b1);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge clk);
                seen = mem_if.mem_req;
            end
            check("rq_req_seen", {31'b0, seen}, 32'd1);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset            = 1'b0;
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mem_if.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) check_reset_outputs("rq");
        auto_ack = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
